// File: rtl/timer_pkg.sv
// Shared timer types: FSM state encoding and the load-time mode constants.
package timer_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic MODE_PERIODIC = 1'b0;
    localparam logic MODE_ONESHOT  = 1'b1;

endpackage

// File: rtl/timer_prescaler.sv
// Tick divider: asserts tick on every (div+1)th enabled cycle; phase freezes while en is low.
// Latency: tick is combinational from the registered phase counter; clr takes effect next cycle.
// Backpressure: none; en is the only throttle and simply holds the phase.
`ifdef TIMER_PRESCALE_EN
module timer_prescaler #(
    parameter int PRESC_WIDTH = 4
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   clr,
    input  logic                   en,
    input  logic [PRESC_WIDTH-1:0] div,
    output logic                   tick
);

    logic [PRESC_WIDTH-1:0] phase_q, phase_d;

    always_comb begin
        tick    = en && (phase_q == div);
        phase_d = phase_q;
        if (clr || tick) begin
            phase_d = '0;
        end else if (en) begin
            phase_d = phase_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            phase_q <= '0;
        end else begin
            phase_q <= phase_d;
        end
    end

endmodule
`endif

// File: rtl/timer_prog.sv
// Programmable periodic/one-shot timer; optional prescaler under macro TIMER_PRESCALE_EN.
// Latency: first count on the second enabled edge after reset/load; rollover one cycle after the terminal tick.
// Backpressure: none; en pauses counting and prescaler phase, load always wins.
module timer_prog
    import timer_pkg::*;
#(
    parameter int WIDTH       = 8,
    parameter int TERM        = 216,
    parameter int PRESC_WIDTH = 4
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   en,
    input  logic                   load,
    input  logic [WIDTH-1:0]       term,
    input  logic                   mode,
`ifdef TIMER_PRESCALE_EN
    input  logic [PRESC_WIDTH-1:0] presc,
`endif
    output logic [WIDTH-1:0]       count,
    output logic                   rollover,
    output logic                   busy,
    output logic                   done
);

    localparam logic [WIDTH-1:0] TERM_RST = TERM[WIDTH-1:0];

    if (WIDTH < 1 || PRESC_WIDTH < 1) begin : g_bad_params
        $error("timer_prog: WIDTH and PRESC_WIDTH must be at least 1");
    end

    state_t           state_q, state_d;
    logic [WIDTH-1:0] count_q, count_d;
    logic [WIDTH-1:0] term_q, term_d;
    logic             mode_q, mode_d;
    logic             roll_q, roll_d;
    logic             run_en;
    logic             tick;

    assign run_en = (state_q == RUN) && en;

`ifdef TIMER_PRESCALE_EN
    logic [PRESC_WIDTH-1:0] presc_q, presc_d;

    timer_prescaler #(
        .PRESC_WIDTH (PRESC_WIDTH)
    ) u_prescaler (
        .clk   (clk),
        .reset (reset),
        .clr   (load),
        .en    (run_en),
        .div   (presc_q),
        .tick  (tick)
    );
`else
    assign tick = run_en;
`endif

    always_comb begin
        state_d = state_q;
        count_d = count_q;
        term_d  = term_q;
        mode_d  = mode_q;
        roll_d  = 1'b0;
`ifdef TIMER_PRESCALE_EN
        presc_d = presc_q;
`endif
        // load overrides everything, including a coincident terminal tick
        if (load) begin
            term_d  = term;
            mode_d  = mode;
            count_d = '0;
            state_d = IDLE;
`ifdef TIMER_PRESCALE_EN
            presc_d = presc;
`endif
        end else begin
            case (state_q)
                IDLE: begin
                    if (en) begin
                        state_d = RUN;
                    end
                end
                RUN: begin
                    if (tick) begin
                        if (count_q == term_q) begin
                            count_d = '0;
                            roll_d  = 1'b1;
                            if (mode_q == MODE_ONESHOT) begin
                                state_d = DONE;
                            end
                        end else begin
                            count_d = count_q + 1'b1;
                        end
                    end
                end
                DONE: begin
                    state_d = DONE;
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            count_q <= '0;
            term_q  <= TERM_RST;
            mode_q  <= MODE_PERIODIC;
            roll_q  <= 1'b0;
`ifdef TIMER_PRESCALE_EN
            presc_q <= '0;
`endif
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            term_q  <= term_d;
            mode_q  <= mode_d;
            roll_q  <= roll_d;
`ifdef TIMER_PRESCALE_EN
            presc_q <= presc_d;
`endif
        end
    end

    assign count    = count_q;
    assign rollover = roll_q;
    assign busy     = (state_q == RUN);
    assign done     = (state_q == DONE);

endmodule
